// File: rtl/io_bus_ctrl_pkg.sv
// Shared types and codes for the IO bus master and its device-side models.
package io_bus_ctrl_pkg;

    // Bus master phases
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // Completion status reported alongside done
    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TO  = 2'b01;
    localparam logic [1:0] ERR_DEC = 2'b10;

    // Captured request kind; a write clears both read targets
    typedef struct packed {
        logic wr;
        logic rd_a;
        logic rd_b;
    } req_type_t;

    // Write wins over reads; both read enables together form one read to both ports
    function automatic req_type_t classify_req(input logic wt, input logic ra, input logic rb);
        req_type_t r;
        r.wr   = wt;
        r.rd_a = ~wt & ra;
        r.rd_b = ~wt & rb;
        return r;
    endfunction

endpackage

// File: rtl/io_bus_ctrl_addr_decode.sv
// Address decoder: device index -> one-hot chip select, register offset, valid flag.
module io_addr_decode #(
    parameter int unsigned IONUM    = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned REG_BITS = 4
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [IONUM-1:0]    cs_c,
    output logic [REG_BITS-1:0] reg_addr_c,
    output logic                valid_c
);

    localparam int unsigned IDX_W = ADDR_W - REG_BITS;

    logic [IDX_W-1:0] dev_idx;

    assign dev_idx    = addr[ADDR_W-1:REG_BITS];
    assign reg_addr_c = addr[REG_BITS-1:0];

    // One-hot select; an index beyond the device count selects nothing
    always_comb begin
        cs_c    = '0;
        valid_c = 1'b0;
        for (int unsigned k = 0; k < IONUM; k++) begin
            if (dev_idx == IDX_W'(k)) begin
                cs_c[k] = 1'b1;
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Registered, handshaked bus master between the CPU datapath and memory-mapped IO devices.
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter int unsigned IONUM    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned REG_BITS = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wt_en,
    input  logic                    rd_A_en,
    input  logic                    rd_B_en,
    input  logic [ADDR_W-1:0]       addr_in,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    req_ready,
    output logic                    done,
    output logic [1:0]              err,
    output logic [DATA_W-1:0]       data_A_out,
    output logic [DATA_W-1:0]       data_B_out,
    output logic [IONUM-1:0]        cs_io,
    output logic                    wt_io,
    output logic                    rd_io,
    output logic [REG_BITS-1:0]     register_addr_out,
    output logic [DATA_W-1:0]       io_wdata,
    input  logic [IONUM*DATA_W-1:0] io_rdata,
    input  logic [IONUM-1:0]        io_ack
);

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    req_type_t           req_q, req_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                req_ready_q, req_ready_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic [DATA_W-1:0]   data_a_q, data_a_d;
    logic [DATA_W-1:0]   data_b_q, data_b_d;
    logic [IONUM-1:0]    cs_io_q, cs_io_d;
    logic                wt_io_q, wt_io_d;
    logic                rd_io_q, rd_io_d;
    logic [REG_BITS-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;

    logic                accept_c;
    logic [IONUM-1:0]    dec_cs_c;
    logic [REG_BITS-1:0] dec_reg_c;
    logic                dec_valid_c;
    logic                ack_hit_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic                timeout_c;
    logic [DATA_W-1:0]   rdata_sel_c;

    assign accept_c  = (state_q == S_IDLE) & (wt_en | rd_A_en | rd_B_en);
    // Decode the address about to be held so a bad index is seen on the accept cycle
    assign addr_d    = accept_c ? addr_in : addr_q;
    assign ack_hit_c = |(io_ack & cs_io_q);
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign timeout_c = (cnt_inc_c == CNT_MAX);

    io_addr_decode #(
        .IONUM    (IONUM),
        .ADDR_W   (ADDR_W),
        .REG_BITS (REG_BITS)
    ) u_decode (
        .addr       (addr_d),
        .cs_c       (dec_cs_c),
        .reg_addr_c (dec_reg_c),
        .valid_c    (dec_valid_c)
    );

    // Read bus of the currently selected device
    always_comb begin
        rdata_sel_c = '0;
        for (int unsigned k = 0; k < IONUM; k++) begin
            if (cs_io_q[k]) begin
                rdata_sel_c = io_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request latches and access counter
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    req_d   = classify_req(wt_en, rd_A_en, rd_B_en);
                    wdata_d = data_in;
                    state_d = dec_valid_c ? S_SETUP : S_DONE;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_d = cnt_inc_c;
                if (ack_hit_c || timeout_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        done_d      = 1'b0;
        err_d       = ERR_OK;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        cs_io_d     = '0;
        wt_io_d     = 1'b0;
        rd_io_d     = 1'b0;
        reg_addr_d  = '0;
        io_wdata_d  = '0;

        if (state_d == S_SETUP || state_d == S_ACCESS) begin
            cs_io_d    = dec_cs_c;
            reg_addr_d = dec_reg_c;
            io_wdata_d = wdata_d;
        end

        if (state_d == S_ACCESS) begin
            wt_io_d = req_d.wr;
            rd_io_d = ~req_d.wr;
        end

        if (state_d == S_DONE) begin
            done_d = 1'b1;
            if (state_q == S_IDLE) begin
                err_d = ERR_DEC;
            end else if (!ack_hit_c) begin
                err_d = ERR_TO;
            end
        end

        // Ack beats timeout; a timed-out read returns all ones
        if (state_q == S_ACCESS && state_d == S_DONE) begin
            if (req_q.rd_a) begin
                data_a_d = ack_hit_c ? rdata_sel_c : '1;
            end
            if (req_q.rd_b) begin
                data_b_d = ack_hit_c ? rdata_sel_c : '1;
            end
        end
    end

    // Request latches and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= '0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers; reset drops select and strobes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            data_a_q    <= '0;
            data_b_q    <= '0;
            cs_io_q     <= '0;
            wt_io_q     <= 1'b0;
            rd_io_q     <= 1'b0;
            reg_addr_q  <= '0;
            io_wdata_q  <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            cs_io_q     <= cs_io_d;
            wt_io_q     <= wt_io_d;
            rd_io_q     <= rd_io_d;
            reg_addr_q  <= reg_addr_d;
            io_wdata_q  <= io_wdata_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign done              = done_q;
    assign err               = err_q;
    assign data_A_out        = data_a_q;
    assign data_B_out        = data_b_q;
    assign cs_io             = cs_io_q;
    assign wt_io             = wt_io_q;
    assign rd_io             = rd_io_q;
    assign register_addr_out = reg_addr_q;
    assign io_wdata          = io_wdata_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed and randomized checks of io_bus_ctrl against a transaction-level reference model.
module tb_io_bus_ctrl;

    localparam int unsigned IONUM    = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned REG_BITS = 4;
    localparam int unsigned TIMEOUT  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    wt_en, rd_A_en, rd_B_en;
    logic [ADDR_W-1:0]       addr_in;
    logic [DATA_W-1:0]       data_in;
    logic                    req_ready, done;
    logic [1:0]              err;
    logic [DATA_W-1:0]       data_A_out, data_B_out;
    logic [IONUM-1:0]        cs_io;
    logic                    wt_io, rd_io;
    logic [REG_BITS-1:0]     register_addr_out;
    logic [DATA_W-1:0]       io_wdata;
    logic [IONUM*DATA_W-1:0] io_rdata;
    logic [IONUM-1:0]        io_ack;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference copies of the two read ports
    logic [DATA_W-1:0] mdl_a, mdl_b;

    always #5 clk = ~clk;

    io_bus_ctrl #(
        .IONUM    (IONUM),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .REG_BITS (REG_BITS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wt_en             (wt_en),
        .rd_A_en           (rd_A_en),
        .rd_B_en           (rd_B_en),
        .addr_in           (addr_in),
        .data_in           (data_in),
        .req_ready         (req_ready),
        .done              (done),
        .err               (err),
        .data_A_out        (data_A_out),
        .data_B_out        (data_B_out),
        .cs_io             (cs_io),
        .wt_io             (wt_io),
        .rd_io             (rd_io),
        .register_addr_out (register_addr_out),
        .io_wdata          (io_wdata),
        .io_rdata          (io_rdata),
        .io_ack            (io_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction: device acks on its ack_n-th strobe cycle (never if ack_n > TIMEOUT);
    // noise toggles ack bits of unselected devices.
    task automatic run_txn(input string tag, input logic wr, input logic ra, input logic rb,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input int ack_n, input logic [IONUM-1:0] noise);
        logic [27:0]       idx;
        logic              dec_err;
        logic [IONUM-1:0]  sel;
        int                n_acc, exp_done, done_cyc, cs_cyc, wt_cyc, rd_cyc;
        logic [1:0]        exp_err, got_err;
        logic              got_rdy, cs_bad, reg_bad, wd_bad, err_bad;
        logic [DATA_W-1:0] rd_val, got_a, got_b;

        idx     = addr[ADDR_W-1:REG_BITS];
        dec_err = (idx >= 28'(IONUM));
        sel     = '0;
        if (!dec_err) sel[int'(idx[1:0])] = 1'b1;

        if (dec_err) begin
            n_acc = 0; exp_err = 2'b10; exp_done = 1;
        end else if (ack_n <= int'(TIMEOUT)) begin
            n_acc = ack_n; exp_err = 2'b00; exp_done = ack_n + 2;
        end else begin
            n_acc = int'(TIMEOUT); exp_err = 2'b01; exp_done = int'(TIMEOUT) + 2;
        end
        rd_val = (exp_err == 2'b00) ? io_rdata[int'(idx[1:0])*DATA_W +: DATA_W] : '1;

        done_cyc = -1; cs_cyc = 0; wt_cyc = 0; rd_cyc = 0;
        got_err = 2'b11; got_rdy = 1'b1; got_a = '0; got_b = '0;
        cs_bad = 1'b0; reg_bad = 1'b0; wd_bad = 1'b0; err_bad = 1'b0;

        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        wt_en = wr; rd_A_en = ra; rd_B_en = rb; addr_in = addr; data_in = wdata;
        io_ack = noise & ~sel;

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wt_en = 1'b0; rd_A_en = 1'b0; rd_B_en = 1'b0;
                addr_in = $urandom; data_in = $urandom;
            end
            if (cs_io != '0) begin
                cs_cyc++;
                if (cs_io !== sel) cs_bad = 1'b1;
                if (register_addr_out !== addr[REG_BITS-1:0]) reg_bad = 1'b1;
            end
            if ((wt_io || rd_io) && cs_io == '0) cs_bad = 1'b1;
            if (wt_io) wt_cyc++;
            if (rd_io) rd_cyc++;
            if (wt_io && io_wdata !== wdata) wd_bad = 1'b1;
            if (done) begin
                done_cyc = c; got_err = err; got_rdy = req_ready;
                got_a = data_A_out; got_b = data_B_out;
                break;
            end
            if (err !== 2'b00) err_bad = 1'b1;
            io_ack = (noise & ~sel) |
                     (((wt_io || rd_io) && (wt_cyc + rd_cyc) == ack_n) ? sel : '0);
        end
        io_ack = '0;

        if (!wr && ra && !dec_err) mdl_a = rd_val;
        if (!wr && rb && !dec_err) mdl_b = rd_val;

        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, "_err"}, 64'(got_err), 64'(exp_err));
        check({tag, "_err_idle"}, 64'(err_bad), 64'd0);
        check({tag, "_ready_in_done"}, 64'(got_rdy), 64'd0);
        check({tag, "_cs_cycles"}, 64'(cs_cyc), dec_err ? 64'd0 : 64'(n_acc + 1));
        check({tag, "_cs_value"}, 64'(cs_bad), 64'd0);
        check({tag, "_reg_addr"}, 64'(reg_bad), 64'd0);
        check({tag, "_wt_cycles"}, 64'(wt_cyc), wr ? 64'(n_acc) : 64'd0);
        check({tag, "_rd_cycles"}, 64'(rd_cyc), wr ? 64'd0 : 64'(n_acc));
        check({tag, "_wdata"}, 64'(wd_bad), 64'd0);
        check({tag, "_data_A"}, 64'(got_a), 64'(mdl_a));
        check({tag, "_data_B"}, 64'(got_b), 64'(mdl_b));

        @(negedge clk);
        check({tag, "_after"}, 64'({req_ready, done, err}), 64'b1000);
    endtask

    // Guard against a stuck simulation
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        rst_n = 1'b0; wt_en = 1'b0; rd_A_en = 1'b0; rd_B_en = 1'b0;
        addr_in = '0; data_in = '0; io_rdata = '0; io_ack = '0;
        mdl_a = '0; mdl_b = '0;

        // Reset state
        #23;
        check("reset_ctrl", 64'({req_ready, done, err, cs_io, wt_io, rd_io}), 64'b1_0_00_0000_0_0);
        check("reset_bus", 64'({register_addr_out, io_wdata}), 64'd0);
        check("reset_ports", {data_A_out, data_B_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write to dev2 reg5, acked on first ACCESS cycle
        for (int k = 0; k < int'(IONUM); k++) io_rdata[k*DATA_W +: DATA_W] = $urandom;
        run_txn("t1_write", 1'b1, 1'b0, 1'b0, 32'h25, 32'hDEADBEEF, 1, '0);

        // Read A from dev3 with three wait states
        io_rdata[3*DATA_W +: DATA_W] = 32'h1234;
        run_txn("t2_readA", 1'b0, 1'b1, 1'b0, 32'h31, 32'h0, 4, '0);

        // Dual read from dev0
        io_rdata[0*DATA_W +: DATA_W] = 32'hA5A5;
        run_txn("t3_dual", 1'b0, 1'b1, 1'b1, 32'h00, 32'h0, 1, '0);

        // Timeout on dev1 with no ack
        run_txn("t4_timeout", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 100, '0);

        // Decode error (device 5 of 4)
        run_txn("t5_decerr", 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1, '0);

        // Reset in the middle of an access
        rd_A_en = 1'b1; addr_in = 32'h14;
        @(negedge clk);
        rd_A_en = 1'b0;
        @(negedge clk);
        check("t6_in_access", 64'({cs_io, rd_io}), 64'b0010_1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_ctrl", 64'({req_ready, done, err, cs_io, wt_io, rd_io}), 64'b1_0_00_0000_0_0);
        check("t6_reset_ports", {data_A_out, data_B_out}, 64'd0);
        mdl_a = '0; mdl_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t6_no_done", 64'(done_seen), 64'd0);

        // Write and read A together: write only
        io_rdata[2*DATA_W +: DATA_W] = 32'hCAFE0001;
        run_txn("t6_wr_prio", 1'b1, 1'b1, 1'b0, 32'h2A, 32'h600DF00D, 2, '0);

        // Randomized transactions, including timeouts, bad decodes and ack noise
        for (int i = 0; i < 40; i++) begin
            logic [2:0]        typ;
            logic [27:0]       idx;
            logic [ADDR_W-1:0] a;
            int                r;
            typ = 3'($urandom_range(1, 7));
            r = int'($urandom_range(0, 9));
            idx = (r < 6) ? 28'(r) : 28'($urandom);
            a = {idx, 4'($urandom)};
            for (int k = 0; k < int'(IONUM); k++) io_rdata[k*DATA_W +: DATA_W] = $urandom;
            run_txn($sformatf("rnd%0d", i), typ[2], typ[1], typ[0], a, 32'($urandom),
                    int'($urandom_range(1, 10)), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
